acciones_to_display: RTL

ACCIONES_TO_DISPLAY -- requirements
Module: acciones_to_display

---
 rtl/acciones_to_display.sv | 100 ++++++++++
 1 files changed

// File: rtl/acciones_to_display.sv
// Elevator status to 4-digit multiplexed display: floor, constant 9, door code, motion code.
// Digits are sampled every clk; a prescaled scan steps through them, blinking the door digit while open.
module acciones_to_display #(
  parameter int NUM_PISOS   = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLINK_TICKS = 256,
  localparam int PW = ($clog2(NUM_PISOS) < 1) ? 1 : $clog2(NUM_PISOS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] piso,
  input  logic [1:0]    accion,
  input  logic          puertas,
  output logic [3:0]    bcd,
  output logic [3:0]    an,
  output logic          error
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [3:0]    d3_q, d1_q, d0_q;
  logic [3:0]    d3_n, d1_n, d0_n;
  logic          err_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    idx_q, idx_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic          phase_q, phase_n;
  logic [3:0]    an_n, bcd_n, sel;
  logic          tick, in_range;

  always_comb begin
    tick     = (cnt_q == CW'(CLK_DIV - 1));
    cnt_n    = tick ? '0 : cnt_q + 1'b1;
    idx_n    = tick ? idx_q + 2'd1 : idx_q;
    in_range = (32'(piso) < NUM_PISOS);

    d3_n = in_range ? 4'(piso) + 4'd1 : d3_q;
    d1_n = puertas ? 4'd6 : 4'd7;
    case (accion)
      2'd0:    d0_n = 4'd0;
      2'd1:    d0_n = 4'd5;
      2'd2:    d0_n = 4'd8;
      default: d0_n = d0_q;
    endcase
    err_n = !in_range || (accion == 2'd3) || (puertas && (accion != 2'd0));

    // Closed door parks the blink at the start of an on half-period.
    bcnt_n  = bcnt_q;
    phase_n = phase_q;
    if (!puertas) begin
      bcnt_n  = '0;
      phase_n = 1'b1;
    end else if (tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_n  = '0;
        phase_n = ~phase_q;
      end else begin
        bcnt_n = bcnt_q + 1'b1;
      end
    end

    // Outputs are built from next-state values so a tick and a digit change land together.
    an_n = ~(4'b0001 << idx_n);
    case (idx_n)
      2'd0:    sel = d0_n;
      2'd1:    sel = d1_n;
      2'd2:    sel = 4'd9;
      default: sel = d3_n;
    endcase
    bcd_n = ((idx_n == 2'd1) && puertas && !phase_n) ? 4'hF : sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d3_q    <= 4'd1;
      d1_q    <= 4'd7;
      d0_q    <= 4'd0;
      error   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      an      <= 4'b1110;
      bcd     <= 4'h0;
    end else begin
      d3_q    <= d3_n;
      d1_q    <= d1_n;
      d0_q    <= d0_n;
      error   <= err_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      bcnt_q  <= bcnt_n;
      phase_q <= phase_n;
      an      <= an_n;
      bcd     <= bcd_n;
    end
  end

endmodule
